// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  // Controller states: waiting for operands, stepping slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of one arithmetic slice.
  localparam int NIBBLE_W = 4;

  // Number of slices needed to cover an operand of the given width.
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/sub_nibble.sv
// One 4-bit subtract slice: a + ~b + carry_i, built from four full-adder
// stages. carry_o = 1 means "no borrow" out of this slice.
module sub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_i,
  output logic [3:0] diff,
  output logic       carry_o
);

  logic [4:0] carry;

  assign carry[0] = carry_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic b_inv;
    assign b_inv      = ~b[i];
    assign diff[i]    = a[i] ^ b_inv ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv) | (a[i] & carry[i]) | (b_inv & carry[i]);
  end

  assign carry_o = carry[4];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: a - b - borrow_i, one nibble per clock,
// least-significant nibble first, with valid/ready on both sides.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // A partial top slice would silently drop bits, so refuse to elaborate.
  if ((WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be a multiple of 4");
  end

  sub_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             ready_q;
  logic             valid_q;
  logic             borrow_q;
  logic             ovf_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       nib_diff;
  logic             nib_carry;
  int unsigned      base;

  // Select the operand nibbles addressed by the current slice index.
  always_comb begin
    base  = 32'(idx) * 32'(NIBBLE_W);
    a_nib = a_q[base +: NIBBLE_W];
    b_nib = b_q[base +: NIBBLE_W];
  end

  sub_nibble u_slice (
    .a       (a_nib),
    .b       (b_nib),
    .carry_i (carry),
    .diff    (nib_diff),
    .carry_o (nib_carry)
  );

  // Controller, operand capture, result accumulation and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            // A borrow-in is a missing carry-in in the a + ~b + c form.
            carry    <= ~borrow_i;
            result   <= '0;
            idx      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            state    <= RUN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          result[base +: NIBBLE_W] <= nib_diff;
          carry <= nib_carry;
          if (idx == LAST_IDX) begin
            idx      <= '0;
            // The top slice's sum bit 3 is the result sign bit.
            borrow_q <= ~nib_carry;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (nib_diff[3] != a_q[WIDTH-1]);
            valid_q  <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          idx     <= '0;
          carry   <= 1'b0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign diff_o   = result;
  assign borrow_o = borrow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus
// random operands compared against an arithmetic reference model.
module tb_serial_subtractor;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        borrow_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] diff_o;
  logic        borrow_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .borrow_i (borrow_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .diff_o   (diff_o),
    .borrow_o (borrow_o),
    .ovf_o    (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic, returns {ovf, borrow, diff}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    longint u;
    longint s;
    logic [31:0] d;
    logic bo;
    logic ov;
    u  = longint'(a) - longint'(b) - longint'(bin);
    s  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    d  = u[31:0];
    bo = (u < 0);
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ov, bo, d};
  endfunction

  // Present operands and let the accepting edge pass.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int n;
    a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 30) begin tick(); n++; end
    chk("ready_before_accept", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk("ready_low_after_accept", ready_o, 0);
  endtask

  // Wait for valid_o and check latency and result against the model.
  task automatic await_check(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic bin);
    int lat;
    logic [33:0] exp;
    lat = 0;
    while (!valid_o && lat < 30) begin tick(); lat++; end
    exp = model(a, b, bin);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_diff"}, diff_o, exp[31:0]);
    chk({tag, "_borrow"}, borrow_o, exp[32]);
    chk({tag, "_ovf"}, ovf_o, exp[33]);
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic drain();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("valid_low_after_handshake", valid_o, 0);
    chk("ready_high_after_handshake", ready_o, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic bin);
    issue(a, b, bin);
    await_check(tag, a, b, bin);
    drain();
  endtask

  logic [31:0] snap_diff;
  logic        snap_borrow;
  logic        snap_ovf;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rbin;

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = 32'd0; b_i = 32'd0; borrow_i = 1'b0;
    tick(); tick();
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_diff", diff_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Directed corner cases.
    run_op("five_minus_three", 32'd5, 32'd3, 1'b0);
    run_op("zero_minus_one", 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("min_minus_one", 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("max_minus_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("nibble_borrow_in", 32'h0000_0010, 32'h0000_000F, 1'b1);
    chk("const_five_minus_three", model(32'd5, 32'd3, 1'b0), {2'b00, 32'h0000_0002});

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(1, 0));
      run_op("random", ra, rb, rbin);
    end

    // Backpressure: hold DONE while disturbing the inputs.
    ra = 32'h1234_5678; rb = 32'h8765_4321;
    issue(ra, rb, 1'b0);
    await_check("bp_first", ra, rb, 1'b0);
    snap_diff = diff_o; snap_borrow = borrow_o; snap_ovf = ovf_o;
    for (int i = 0; i < 5; i++) begin
      valid_i = ~valid_i;
      a_i = $urandom;
      tick();
      chk("bp_diff_hold", diff_o, snap_diff);
      chk("bp_borrow_hold", borrow_o, snap_borrow);
      chk("bp_ovf_hold", ovf_o, snap_ovf);
      chk("bp_valid_hold", valid_o, 1);
      chk("bp_ready_low", ready_o, 0);
    end

    // Back-to-back: next operands already waiting at the handshake edge.
    ra = 32'hDEAD_BEEF; rb = 32'h0BAD_F00D;
    a_i = ra; b_i = rb; borrow_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("b2b_handshake_valid", valid_o, 0);
    chk("b2b_handshake_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk("b2b_accepted", ready_o, 0);
    await_check("b2b_second", ra, rb, 1'b1);
    drain();

    // Reset in the middle of a computation.
    issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    tick(); tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("midrun_reset_ready", ready_o, 1);
    chk("midrun_reset_valid", valid_o, 0);
    chk("midrun_reset_diff", diff_o, 32'd0);
    chk("midrun_reset_borrow", borrow_o, 0);
    chk("midrun_reset_ovf", ovf_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    run_op("after_reset_nine_minus_four", 32'd9, 32'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
